// File: rtl/tcp_pkg.sv
// Shared constants for the TCP socket table: flag bit indices, canned header flags and
// the one-hot state encoding of the passive-open (listen) entry.
package tcp_pkg;

  localparam int unsigned FLAG_CWR = 0;
  localparam int unsigned FLAG_ECE = 1;
  localparam int unsigned FLAG_URG = 2;
  localparam int unsigned FLAG_ACK_IDX = 3;
  localparam int unsigned FLAG_PSH = 4;
  localparam int unsigned FLAG_RST = 5;
  localparam int unsigned FLAG_SYN = 6;
  localparam int unsigned FLAG_FIN = 7;

  localparam logic [7:0] FLAG_SYN_ACK = 8'h48;
  localparam logic [7:0] FLAG_ACK     = 8'h08;

  localparam int unsigned ST_CLOSED_IDX   = 0;
  localparam int unsigned ST_LISTEN_IDX   = 1;
  localparam int unsigned ST_SYN_RCVD_IDX = 2;
  localparam int unsigned ST_SYN_ACK_IDX  = 3;
  localparam int unsigned ST_EST_IDX      = 4;
  localparam int unsigned NUM_ST          = 5;

  typedef enum logic [NUM_ST-1:0] {
    StClosed     = 5'b00001,
    StListen     = 5'b00010,
    StSynRcvd    = 5'b00100,
    StSynAckSent = 5'b01000,
    StEst        = 5'b10000
  } listen_state_e;

endpackage

// File: rtl/tcp_seq_acc.sv
// Sequence/ack number register: load has priority over a modulo-2^SEQ_W add of a size.
module tcp_seq_acc #(
  parameter int unsigned SEQ_W  = 32,
  parameter int unsigned SIZE_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              load_i,
  input  logic [SEQ_W-1:0]  load_val_i,
  input  logic              add_i,
  input  logic [SIZE_W-1:0] add_size_i,
  output logic [SEQ_W-1:0]  val_o
);

  logic [SEQ_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (add_i) begin
      val_d = val_q + SEQ_W'(add_size_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/tcp_listen_entry.sv
// One passive-open TCP socket: accepts a SYN, issues SYN+ACK, waits for the final ACK and
// tracks seq/ack while established, driving the shared header-generation path.
module tcp_listen_entry
  import tcp_pkg::*;
#(
  parameter int unsigned IP_W   = 32,
  parameter int unsigned PORT_W = 16,
  parameter int unsigned SEQ_W  = 32,
  parameter int unsigned FLAG_W = 8,
  parameter int unsigned SIZE_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              listen_v_i,
  input  logic [PORT_W-1:0] listen_port_i,
  input  logic [SEQ_W-1:0]  listen_isn_i,
  input  logic              close_v_i,
  input  logic              rec_v_i,
  input  logic [IP_W-1:0]   rec_ip_src_i,
  input  logic [PORT_W-1:0] rec_port_src_i,
  input  logic [PORT_W-1:0] rec_port_dst_i,
  input  logic [SIZE_W-1:0] rec_size_i,
  input  logic [SEQ_W-1:0]  rec_seq_i,
  input  logic [SEQ_W-1:0]  rec_ack_i,
  input  logic [FLAG_W-1:0] rec_flag_i,
  input  logic              sent_v_i,
  input  logic [SIZE_W-1:0] send_size_i,
  output logic              listening_o,
  output logic              est_o,
  output logic [IP_W-1:0]   ip_dst_o,
  output logic [PORT_W-1:0] port_src_o,
  output logic [PORT_W-1:0] port_dst_o,
  output logic              force_send_v_o,
  output logic [FLAG_W-1:0] send_flag_o,
  output logic [SEQ_W-1:0]  send_seq_o,
  output logic [SEQ_W-1:0]  send_ack_o
);

  listen_state_e state_q, state_d;
  logic [IP_W-1:0]   ip_dst_q;
  logic [PORT_W-1:0] port_src_q, port_dst_q;
  logic              force_send_q, force_send_d;
  logic [SEQ_W-1:0]  seq_q, ack_q;

  logic st_closed, st_listen, st_syn_rcvd, st_syn_ack, st_est;
  logic match, f_syn, f_ack, f_rst;
  logic syn_ok, retx_syn, est_data;
  logic seq_load, seq_add, ack_load, ack_add;
  logic [SEQ_W-1:0]  seq_load_val, ack_load_val;
  logic [SIZE_W-1:0] seq_add_size;

  assign st_closed   = state_q[ST_CLOSED_IDX];
  assign st_listen   = state_q[ST_LISTEN_IDX];
  assign st_syn_rcvd = state_q[ST_SYN_RCVD_IDX];
  assign st_syn_ack  = state_q[ST_SYN_ACK_IDX];
  assign st_est      = state_q[ST_EST_IDX];

  assign f_syn = rec_flag_i[FLAG_SYN];
  assign f_ack = rec_flag_i[FLAG_ACK_IDX];
  assign f_rst = rec_flag_i[FLAG_RST];

  assign match = rec_v_i && (rec_ip_src_i == ip_dst_q) && (rec_port_src_i == port_dst_q) &&
                 (rec_port_dst_i == port_src_q);

  assign syn_ok   = rec_v_i && f_syn && !f_ack && !f_rst && (rec_port_dst_i == port_src_q);
  assign retx_syn = match && !f_rst && f_syn && !f_ack;
  assign est_data = match && !f_rst && (rec_size_i != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= StClosed;
      force_send_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      force_send_q <= force_send_d;
    end
  end

  // Next-state logic; close wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClosed:     if (listen_v_i) state_d = StListen;
      StListen:     if (syn_ok) state_d = StSynRcvd;
      StSynRcvd:    if (sent_v_i) state_d = StSynAckSent;
      StSynAckSent: begin
        if (match && f_rst)                   state_d = StListen;
        else if (retx_syn)                    state_d = StSynRcvd;
        else if (match && f_ack && rec_ack_i == seq_q) state_d = StEst;
      end
      StEst:        if (match && f_rst) state_d = StListen;
      default:      state_d = StClosed;
    endcase
    if (close_v_i) state_d = StClosed;
    force_send_d = !close_v_i && ((state_d == StSynRcvd) || (st_est && est_data));
  end

  // Output decode.
  always_comb begin
    listening_o    = st_listen;
    est_o          = st_est;
    force_send_v_o = force_send_q;
    send_flag_o    = '0;
    if (st_syn_rcvd || st_syn_ack) send_flag_o = FLAG_SYN_ACK;
    if (st_est)                    send_flag_o = FLAG_ACK;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      ip_dst_q   <= '0;
      port_src_q <= '0;
      port_dst_q <= '0;
    end else if (!close_v_i) begin
      if (st_closed && listen_v_i) port_src_q <= listen_port_i;
      if (st_listen && syn_ok) begin
        ip_dst_q   <= rec_ip_src_i;
        port_dst_q <= rec_port_src_i;
      end
    end
  end

  // The SYN consumes one sequence number; a retransmitted SYN rewinds it to the ISN.
  assign seq_load     = !close_v_i && ((st_closed && listen_v_i) || (st_syn_ack && retx_syn));
  assign seq_load_val = st_closed ? listen_isn_i : seq_q - SEQ_W'(1);
  assign seq_add      = !close_v_i && sent_v_i && (st_syn_rcvd || st_est);
  assign seq_add_size = st_syn_rcvd ? SIZE_W'(1) : send_size_i;

  assign ack_load     = !close_v_i && ((st_closed && listen_v_i) || (st_listen && syn_ok));
  assign ack_load_val = st_closed ? '0 : rec_seq_i + SEQ_W'(1);
  assign ack_add      = !close_v_i && st_est && est_data;

  tcp_seq_acc #(.SEQ_W(SEQ_W), .SIZE_W(SIZE_W)) u_seq (
    .clk        (clk),
    .nreset     (nreset),
    .load_i     (seq_load),
    .load_val_i (seq_load_val),
    .add_i      (seq_add),
    .add_size_i (seq_add_size),
    .val_o      (seq_q)
  );

  tcp_seq_acc #(.SEQ_W(SEQ_W), .SIZE_W(SIZE_W)) u_ack (
    .clk        (clk),
    .nreset     (nreset),
    .load_i     (ack_load),
    .load_val_i (ack_load_val),
    .add_i      (ack_add),
    .add_size_i (rec_size_i),
    .val_o      (ack_q)
  );

  assign ip_dst_o   = ip_dst_q;
  assign port_src_o = port_src_q;
  assign port_dst_o = port_dst_q;
  assign send_seq_o = seq_q;
  assign send_ack_o = ack_q;

  a_state_onehot: assert property (@(posedge clk) disable iff (!nreset) $onehot(state_q));

endmodule

// File: tb/tb_tcp_listen_entry.sv
// Scoreboard bench for tcp_listen_entry: expected header state is queued with each stimulus
// cycle and compared one clock later.
module tb_tcp_listen_entry;

  logic        clk = 1'b0;
  logic        nreset;
  logic        listen_v_i;
  logic [15:0] listen_port_i;
  logic [31:0] listen_isn_i;
  logic        close_v_i;
  logic        rec_v_i;
  logic [31:0] rec_ip_src_i;
  logic [15:0] rec_port_src_i, rec_port_dst_i, rec_size_i;
  logic [31:0] rec_seq_i, rec_ack_i;
  logic [7:0]  rec_flag_i;
  logic        sent_v_i;
  logic [15:0] send_size_i;
  logic        listening_o, est_o, force_send_v_o;
  logic [31:0] ip_dst_o;
  logic [15:0] port_src_o, port_dst_o;
  logic [7:0]  send_flag_o;
  logic [31:0] send_seq_o, send_ack_o;

  localparam logic [31:0] PeerIp = 32'h0a00_0002;
  localparam logic [15:0] PeerPort = 16'h1234;
  localparam logic [7:0]  FSyn = 8'h40, FAck = 8'h08, FRst = 8'h20;

  typedef struct {
    string       name;
    logic        lis;
    logic        est;
    logic        fs;
    logic [7:0]  flag;
    logic [31:0] seq;
    logic [31:0] ack;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  tcp_listen_entry dut (
    .clk            (clk),
    .nreset         (nreset),
    .listen_v_i     (listen_v_i),
    .listen_port_i  (listen_port_i),
    .listen_isn_i   (listen_isn_i),
    .close_v_i      (close_v_i),
    .rec_v_i        (rec_v_i),
    .rec_ip_src_i   (rec_ip_src_i),
    .rec_port_src_i (rec_port_src_i),
    .rec_port_dst_i (rec_port_dst_i),
    .rec_size_i     (rec_size_i),
    .rec_seq_i      (rec_seq_i),
    .rec_ack_i      (rec_ack_i),
    .rec_flag_i     (rec_flag_i),
    .sent_v_i       (sent_v_i),
    .send_size_i    (send_size_i),
    .listening_o    (listening_o),
    .est_o          (est_o),
    .ip_dst_o       (ip_dst_o),
    .port_src_o     (port_src_o),
    .port_dst_o     (port_dst_o),
    .force_send_v_o (force_send_v_o),
    .send_flag_o    (send_flag_o),
    .send_seq_o     (send_seq_o),
    .send_ack_o     (send_ack_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic lis, input logic est, input logic fs,
                            input logic [7:0] flag, input logic [31:0] seq,
                            input logic [31:0] ack);
    exp_t e;
    e.name = name; e.lis = lis; e.est = est; e.fs = fs;
    e.flag = flag; e.seq = seq; e.ack = ack;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    listen_v_i = 1'b0; close_v_i = 1'b0; rec_v_i = 1'b0; sent_v_i = 1'b0;
    rec_flag_i = '0; rec_size_i = '0; send_size_i = '0;
  endtask

  // Advance one clock, then compare the oldest queued expectation against the outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    idle_inputs();
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, ".listening"}, 32'(listening_o), 32'(e.lis));
      check({e.name, ".est"}, 32'(est_o), 32'(e.est));
      check({e.name, ".force_send"}, 32'(force_send_v_o), 32'(e.fs));
      check({e.name, ".flag"}, 32'(send_flag_o), 32'(e.flag));
      check({e.name, ".seq"}, send_seq_o, e.seq);
      check({e.name, ".ack"}, send_ack_o, e.ack);
    end
  endtask

  task automatic rec(input logic [31:0] ip, input logic [15:0] sport, input logic [15:0] dport,
                     input logic [7:0] flag, input logic [31:0] seq, input logic [31:0] ack,
                     input logic [15:0] size);
    rec_v_i = 1'b1; rec_ip_src_i = ip; rec_port_src_i = sport; rec_port_dst_i = dport;
    rec_flag_i = flag; rec_seq_i = seq; rec_ack_i = ack; rec_size_i = size;
  endtask

  task automatic listen(input logic [15:0] port, input logic [31:0] isn);
    listen_v_i = 1'b1; listen_port_i = port; listen_isn_i = isn;
  endtask

  task automatic sent(input logic [15:0] size);
    sent_v_i = 1'b1; send_size_i = size;
  endtask

  initial begin
    nreset = 1'b0;
    listen_port_i = '0; listen_isn_i = '0;
    rec_ip_src_i = '0; rec_port_src_i = '0; rec_port_dst_i = '0;
    rec_seq_i = '0; rec_ack_i = '0;
    idle_inputs();
    tick();
    expect_out("reset", 0, 0, 0, 8'h00, 32'h0, 32'h0);
    tick();
    check("reset.ip_dst", ip_dst_o, 32'h0);
    nreset = 1'b1;

    listen(16'h0050, 32'h0000_1000);
    expect_out("listen", 1, 0, 0, 8'h00, 32'h1000, 32'h0);
    tick();
    check("listen.port_src", 32'(port_src_o), 32'h50);

    rec(PeerIp, PeerPort, 16'h0051, FSyn, 32'h5000, 32'h0, 16'd0);
    expect_out("syn_wrong_port", 1, 0, 0, 8'h00, 32'h1000, 32'h0);
    tick();

    rec(PeerIp, PeerPort, 16'h0050, FSyn, 32'h5000, 32'h0, 16'd0);
    expect_out("syn", 0, 0, 1, 8'h48, 32'h1000, 32'h5001);
    tick();
    check("syn.ip_dst", ip_dst_o, PeerIp);
    check("syn.port_dst", 32'(port_dst_o), 32'(PeerPort));

    expect_out("syn_rcvd_hold", 0, 0, 1, 8'h48, 32'h1000, 32'h5001);
    tick();

    sent(16'd77);
    expect_out("synack_sent", 0, 0, 0, 8'h48, 32'h1001, 32'h5001);
    tick();

    rec(PeerIp, PeerPort, 16'h0050, FAck, 32'h5001, 32'h1005, 16'd0);
    expect_out("ack_wrong_num", 0, 0, 0, 8'h48, 32'h1001, 32'h5001);
    tick();

    rec(32'h0a00_0003, PeerPort, 16'h0050, FAck, 32'h5001, 32'h1001, 16'd0);
    expect_out("ack_wrong_ip", 0, 0, 0, 8'h48, 32'h1001, 32'h5001);
    tick();

    rec(PeerIp, PeerPort, 16'h0050, FAck, 32'h5001, 32'h1001, 16'd0);
    expect_out("est", 0, 1, 0, 8'h08, 32'h1001, 32'h5001);
    tick();

    rec(PeerIp, PeerPort, 16'h0050, FAck, 32'h5001, 32'h1001, 16'd100);
    sent(16'd20);
    expect_out("data_rx_tx", 0, 1, 1, 8'h08, 32'h1015, 32'h5065);
    tick();
    expect_out("ack_pulse_end", 0, 1, 0, 8'h08, 32'h1015, 32'h5065);
    tick();

    rec(PeerIp, 16'h1235, 16'h0050, FAck, 32'h5065, 32'h1015, 16'd50);
    expect_out("data_wrong_port", 0, 1, 0, 8'h08, 32'h1015, 32'h5065);
    tick();

    rec(PeerIp, PeerPort, 16'h0050, FRst, 32'h5065, 32'h0, 16'd0);
    expect_out("rst_in_est", 1, 0, 0, 8'h00, 32'h1015, 32'h5065);
    tick();

    close_v_i = 1'b1;
    expect_out("close", 0, 0, 0, 8'h00, 32'h1015, 32'h5065);
    tick();

    listen(16'h0050, 32'hFFFF_FFFF);
    expect_out("listen_wrap", 1, 0, 0, 8'h00, 32'hFFFF_FFFF, 32'h0);
    tick();
    rec(PeerIp, PeerPort, 16'h0050, FSyn, 32'h0000_7FFF, 32'h0, 16'd0);
    expect_out("syn_wrap", 0, 0, 1, 8'h48, 32'hFFFF_FFFF, 32'h8000);
    tick();
    sent(16'd5);
    expect_out("sent_wrap", 0, 0, 0, 8'h48, 32'h0, 32'h8000);
    tick();
    rec(PeerIp, PeerPort, 16'h0050, FSyn, 32'h0000_7FFF, 32'h0, 16'd0);
    expect_out("dup_syn", 0, 0, 1, 8'h48, 32'hFFFF_FFFF, 32'h8000);
    tick();
    sent(16'd0);
    expect_out("resent", 0, 0, 0, 8'h48, 32'h0, 32'h8000);
    tick();
    rec(PeerIp, PeerPort, 16'h0050, FAck, 32'h8000, 32'h0, 16'd0);
    close_v_i = 1'b1;
    expect_out("close_vs_ack", 0, 0, 0, 8'h00, 32'h0, 32'h8000);
    tick();

    listen(16'h0050, 32'h0000_2000);
    expect_out("listen3", 1, 0, 0, 8'h00, 32'h2000, 32'h0);
    tick();
    rec(PeerIp, PeerPort, 16'h0050, FSyn, 32'h0000_0100, 32'h0, 16'd0);
    expect_out("syn3", 0, 0, 1, 8'h48, 32'h2000, 32'h101);
    tick();
    sent(16'd0);
    expect_out("sent3", 0, 0, 0, 8'h48, 32'h2001, 32'h101);
    tick();
    rec(PeerIp, PeerPort, 16'h0050, FAck, 32'h101, 32'h2001, 16'd0);
    expect_out("est3", 0, 1, 0, 8'h08, 32'h2001, 32'h101);
    tick();
    rec(PeerIp, PeerPort, 16'h0050, FAck, 32'h101, 32'h2001, 16'd4);
    nreset = 1'b0;
    expect_out("reset_in_est", 0, 0, 0, 8'h00, 32'h0, 32'h0);
    tick();
    check("reset_in_est.ip_dst", ip_dst_o, 32'h0);
    check("reset_in_est.port_src", 32'(port_src_o), 32'h0);
    check("reset_in_est.port_dst", 32'(port_dst_o), 32'h0);
    expect_out("reset_no_pulse", 0, 0, 0, 8'h00, 32'h0, 32'h0);
    tick();

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tcp_listen_entry.md
Name: tcp_listen_entry

Overview:
Passive-open (responder/server) counterpart of the active-open socket entry. It manages one listening TCP socket. It accepts a SYN from any peer, requests a SYN+ACK, waits for the peer's final ACK and then tracks seq/ack numbers while the connection is established. It sits beside the active entries in the TCP socket table and drives the same header-generation path (force_send, send_flag/seq/ack).

Parameters:
IP_W, 32, IP address width
PORT_W, 16, TCP port width
SEQ_W, 32, seq/ack number width
FLAG_W, 8, flag field width; index CWR0 ECE1 URG2 ACK3 PSH4 RST5 SYN6 FIN7
SIZE_W, 16, payload byte count width

Ports:
clk  in  1  clock
nreset  in  1  synchronous active-low reset
listen_v_i  in  1  open passive socket (accepted in CLOSED only)
listen_port_i  in  PORT_W  local port to listen on
listen_isn_i  in  SEQ_W  our initial sequence number
close_v_i  in  1  abort socket, return to CLOSED
rec_v_i  in  1  valid received TCP header
rec_ip_src_i  in  IP_W  sender IP
rec_port_src_i  in  PORT_W  sender port
rec_port_dst_i  in  PORT_W  destination port
rec_size_i  in  SIZE_W  payload bytes
rec_seq_i  in  SEQ_W  received seq
rec_ack_i  in  SEQ_W  received ack
rec_flag_i  in  FLAG_W  received flags
sent_v_i  in  1  header built from send_* was transmitted
send_size_i  in  SIZE_W  payload bytes of that packet
listening_o  out  1  state LISTEN
est_o  out  1  state EST
ip_dst_o  out  IP_W  peer IP
port_src_o  out  PORT_W  local port
port_dst_o  out  PORT_W  peer port
force_send_v_o  out  1  request packet transmission
send_flag_o  out  FLAG_W  flags for next packet
send_seq_o  out  SEQ_W  seq for next packet
send_ack_o  out  SEQ_W  ack for next packet

Behaviour:
- Reset: nreset synchronous, active-low, clock clk. State CLOSED; all data registers (ip, ports, seq, ack) = 0; force_send_v_o=0, send_flag_o=0, listening_o=0, est_o=0.
- State register: one-hot, one of CLOSED, LISTEN, SYN_RCVD, SYN_ACK_SENT, EST. All transitions take effect on the next clk edge.
- match = rec_v_i & rec_ip_src_i==ip_dst_q & rec_port_src_i==port_dst_q & rec_port_dst_i==port_src_q.
- close_v_i has top priority in every state: next state CLOSED, force-send pulse cleared, data registers hold.
- CLOSED: listen_v_i -> LISTEN; load port_src<=listen_port_i, seq<=listen_isn_i, ack<=0. Ignored in other states.
- LISTEN: rec_v_i & SYN & ~ACK & ~RST & rec_port_dst_i==port_src_q -> SYN_RCVD; load ip_dst<=rec_ip_src_i, port_dst<=rec_port_src_i, ack<=rec_seq_i+1. All other packets ignored.
- SYN_RCVD: force_send_v_o=1 (level) until sent_v_i; sent_v_i -> SYN_ACK_SENT, seq<=seq+1 (SYN consumes one number; send_size_i ignored).
- SYN_ACK_SENT: force_send_v_o=0.
  - match & RST -> LISTEN.
  - Else match & SYN & ~ACK (retransmitted SYN) -> SYN_RCVD, seq<=seq-1 so the SYN+ACK is reissued with the ISN.
  - Else match & ACK & rec_ack_i==seq_q -> EST.
  - ACK with wrong ack number: ignored.
- EST:
  - match & RST -> LISTEN.
  - match & rec_size_i!=0 -> ack<=ack+rec_size_i, and force_send_v_o pulses high for exactly one cycle, the cycle after the packet.
  - sent_v_i -> seq<=seq+send_size_i.
  - Receive and send in the same cycle both apply independently.
- send_flag_o: 0x00 in CLOSED/LISTEN; 0x48 (SYN|ACK) in SYN_RCVD and SYN_ACK_SENT; 0x08 (ACK) in EST.
- send_seq_o=seq_q, send_ack_o=ack_q, both registered. Header values are valid independently of force_send_v_o.
- Arithmetic: sizes zero-extended to SEQ_W; all seq/ack sums are modulo 2^SEQ_W (carry discarded). 0xFFFFFFFF+1 = 0.
- sent_v_i in CLOSED, LISTEN or SYN_ACK_SENT: no effect.
- Reset mid-connection: immediately CLOSED with all registers 0; no ACK pulse is emitted.
- Formal: state vector is $onehot at every cycle after reset.

Decomposition:
- Package tcp_pkg holds:
  - flag index localparams (CWR..FIN);
  - FLAG_SYN_ACK=8'h48 and FLAG_ACK=8'h08 constants;
  - listen state enum/one-hot index constants.
- Sub-module tcp_seq_acc (SEQ_W/SIZE_W params): register with load value, load enable, add-size enable and modulo add. Instantiated twice, for seq and for ack.

Test Plan:
1. Reset, then listen_v_i with port 0x0050 and ISN 0x1000 -> listening_o=1, send_flag_o=0, force_send_v_o=0.
2. Handshake:
   - SYN from 10.0.0.2:0x1234 to 0x0050, seq 0x5000 -> SYN_RCVD, force_send=1, flag 0x48, seq 0x1000, ack 0x5001.
   - sent_v_i -> seq 0x1001.
   - ACK with rec_ack 0x1001 -> est_o=1, flag 0x08.
3. In EST, rec 100-byte data from the peer -> ack 0x5065, force_send one-cycle pulse the next cycle. In the same cycle as the receive, sent_v_i size 20 -> seq 0x1015.
4. Filtering:
   - SYN to port 0x0051 in LISTEN: ignored.
   - In SYN_ACK_SENT, ACK with rec_ack 0x1005: ignored.
   - ACK from a different IP: ignored.
   - In each case state is unchanged.
5. Wrap and retransmit:
   - ISN 0xFFFFFFFF -> after SYN+ACK sent, seq = 0x00000000.
   - Duplicate SYN in SYN_ACK_SENT -> SYN_RCVD, seq back to 0xFFFFFFFF.
6. Abort paths:
   - RST in EST -> LISTEN.
   - close_v_i together with a matching ACK in SYN_ACK_SENT -> CLOSED.
   - nreset low during EST -> all outputs 0 the next cycle.
